// File: rtl/cmp_pkg.sv
// cmp_pkg -- shared definitions for the XNOR/XOR compare-and-accumulate block.
//   state_t   : statistics FSM encoding (CLEAN / ERR / SAT), exposed on the
//               2-bit state port of xnor_cmp_acc.
//   MODE_XNOR : MODE value selecting z = ~(x ^ y).
//   MODE_XOR  : MODE value selecting z =   x ^ y.
package cmp_pkg;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    ERR   = 2'd1,
    SAT   = 2'd2
  } state_t;

  localparam int MODE_XNOR = 0;
  localparam int MODE_XOR  = 1;

endpackage

// File: rtl/xnor_cmp_acc_popcount.sv
// popcount -- purely combinational population count built as a balanced
// binary adder tree.
//   bits : input vector, WIDTH bits
//   cnt  : number of ones in bits, $clog2(WIDTH+1) bits
module popcount #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]             bits,
  output logic [$clog2(WIDTH+1)-1:0]   cnt
);

  localparam int unsigned CW = $clog2(WIDTH+1);
  localparam int unsigned LV = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int unsigned N2 = 1 << LV;

  // node[0] holds the input bits (zero-padded to a power of two); each
  // further level sums adjacent pairs of the level below.
  logic [CW-1:0] node [LV+1][N2];

  always_comb begin
    for (int unsigned l = 0; l <= LV; l++) begin
      for (int unsigned i = 0; i < N2; i++) begin
        node[l][i] = '0;
      end
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      node[0][i] = CW'(bits[i]);
    end
    for (int unsigned l = 1; l <= LV; l++) begin
      for (int unsigned i = 0; i < (N2 >> l); i++) begin
        node[l][i] = node[l-1][2*i] + node[l-1][2*i+1];
      end
    end
    cnt = node[LV][0];
  end

endmodule

// File: rtl/xnor_cmp_acc.sv
// xnor_cmp_acc -- registered bitwise XNOR/XOR comparator with saturating
// mismatch statistics.
//   clk, resetn        : clock, synchronous active-low reset
//   in_valid, x, y     : sample strobe and WIDTH-bit operands
//   clear              : synchronous statistics clear (wins over counting)
//   z, z_valid, eq     : registered result, its strobe, last-sample equality
//   samples            : accepted sample count
//   mism_samples       : count of samples with x != y
//   mism_bits          : running sum of popcount(x ^ y)
//   first_idx/_seen    : samples value at the first mismatch, and its valid flag
//   state              : FSM state (CLEAN / ERR / SAT)
module xnor_cmp_acc
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             clear,
  output logic [WIDTH-1:0] z,
  output logic             z_valid,
  output logic             eq,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] mism_samples,
  output logic [CNT_W-1:0] mism_bits,
  output logic [CNT_W-1:0] first_idx,
  output logic             first_seen,
  output logic [1:0]       state
);

  localparam int PW = $clog2(WIDTH+1);
  // Sum width wide enough for any counter plus any popcount without overflow.
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] samples_d, mism_samples_d, mism_bits_d, first_idx_d;
  logic             first_seen_d;
  logic [WIDTH-1:0] diff, result;
  logic [PW-1:0]    pc;
  logic             mism;

  assign diff   = x ^ y;
  assign mism   = (x != y);
  assign result = (MODE == MODE_XOR) ? diff : ~diff;
  assign state  = state_q;

  popcount #(.WIDTH(WIDTH)) u_popcount (
    .bits (diff),
    .cnt  (pc)
  );

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [SW-1:0]    b);
    logic [SW-1:0] s;
    s = SW'(a) + b;
    return (s > SW'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= CLEAN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    samples_d      = samples;
    mism_samples_d = mism_samples;
    mism_bits_d    = mism_bits;
    first_idx_d    = first_idx;
    first_seen_d   = first_seen;

    if (clear) begin
      state_d        = CLEAN;
      samples_d      = '0;
      mism_samples_d = '0;
      mism_bits_d    = '0;
      first_idx_d    = '0;
      first_seen_d   = 1'b0;
    end else if (in_valid && state_q != SAT) begin
      samples_d   = sat_add(samples, SW'(1));
      mism_bits_d = sat_add(mism_bits, SW'(pc));
      if (mism) begin
        mism_samples_d = sat_add(mism_samples, SW'(1));
      end
      if (mism && state_q == CLEAN) begin
        first_idx_d  = samples;
        first_seen_d = 1'b1;
        state_d      = ERR;
      end
      // Saturation is judged on the post-update values, so SAT is entered on
      // the same edge a counter lands on all ones and overrides CLEAN->ERR.
      if (samples_d == CNT_MAX || mism_samples_d == CNT_MAX ||
          mism_bits_d == CNT_MAX) begin
        state_d = SAT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      z            <= '0;
      z_valid      <= 1'b0;
      eq           <= 1'b0;
      samples      <= '0;
      mism_samples <= '0;
      mism_bits    <= '0;
      first_idx    <= '0;
      first_seen   <= 1'b0;
    end else begin
      z_valid      <= in_valid;
      if (in_valid) begin
        z  <= result;
        eq <= ~mism;
      end
      samples      <= samples_d;
      mism_samples <= mism_samples_d;
      mism_bits    <= mism_bits_d;
      first_idx    <= first_idx_d;
      first_seen   <= first_seen_d;
    end
  end

endmodule

// File: doc/xnor_cmp_acc.md
XNOR_CMP_ACC -- requirements
Module: xnor_cmp_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the compared vectors x, y and the result vector z.
REQ-002 SHALL have parameter CNT_W, default 16: width of every statistics counter.
REQ-003 SHALL have parameter MODE, default 0: 0 gives z = bitwise XNOR of x and y; 1 gives z = bitwise XOR of x and y.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset is synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: x and y carry a sample this cycle.
REQ-007 SHALL have ports x and y, input, WIDTH bits each: operand vectors.
REQ-008 SHALL have port clear, input, 1 bit: synchronous statistics clear.
REQ-009 SHALL have port z, output, WIDTH bits: registered bitwise result.
REQ-010 SHALL have port z_valid, output, 1 bit: z holds a new result.
REQ-011 SHALL have port eq, output, 1 bit: the last accepted sample had x == y.
REQ-012 SHALL have port samples, output, CNT_W bits: count of accepted samples.
REQ-013 SHALL have port mism_samples, output, CNT_W bits: count of samples with x != y.
REQ-014 SHALL have port mism_bits, output, CNT_W bits: total of the differing-bit counts (popcount of x XOR y) over all samples.
REQ-015 SHALL have port first_idx, output, CNT_W bits: value of samples at the first mismatching sample.
REQ-016 SHALL have port first_seen, output, 1 bit: first_idx is valid.
REQ-017 SHALL have port state, output, 2 bits: current FSM state.

Function
REQ-018 SHALL, on a cycle with in_valid=1, register z (per MODE) and eq, and assert z_valid on the following cycle (latency 1).
REQ-019 SHALL hold z and eq, and drive z_valid=0, on any cycle after one with in_valid=0.
REQ-020 SHALL implement FSM states CLEAN=0, ERR=1, SAT=2.
REQ-021 SHALL move CLEAN->ERR when an accepted sample has x != y, and SHALL then load first_idx with the pre-increment value of samples and set first_seen.
REQ-022 SHALL, in ERR, leave first_idx and first_seen unchanged on later mismatches.
REQ-023 SHALL enter SAT from CLEAN or ERR when any counter reaches 2^CNT_W-1 (all ones).
REQ-024 SHALL, in SAT, freeze all counters; z, z_valid and eq keep updating.
REQ-025 SHALL, on each accepted sample outside SAT, increment samples by 1, increment mism_samples by 1 if x != y, and add popcount(x XOR y) to mism_bits.
REQ-026 SHALL saturate every counter addition at 2^CNT_W-1; it never wraps.
REQ-027 SHALL, when clear=1 (any state): zero all counters, clear first_seen and first_idx, and go to CLEAN the next cycle.
REQ-028 SHALL, when clear and in_valid are both 1, give clear priority for statistics (the sample is not counted) while z, eq and z_valid still update from that sample.
REQ-029 SHALL compute popcount at the full WIDTH; the sum into mism_bits is zero-extended or saturated to CNT_W.

Reset
REQ-030 SHALL, when resetn=0 at a rising clk edge, set z=0, z_valid=0, eq=0, all counters 0, first_idx=0, first_seen=0, state=CLEAN.
REQ-031 SHALL discard any in-flight sample on reset mid-operation; reset overrides clear and in_valid.

Structure
REQ-032 SHALL place the state encoding (CLEAN/ERR/SAT) and the MODE constants (MODE_XNOR=0, MODE_XOR=1) in shared package cmp_pkg.
REQ-033 SHALL implement the popcount in sub-module popcount (parameter WIDTH, purely combinational adder tree).

Verification (WIDTH=8, CNT_W=16, MODE=0 unless stated)
REQ-034 SHALL cover: x=0xA5, y=0xA5, in_valid=1 for one cycle -> next cycle z=0xFF, z_valid=1, eq=1, samples=1, mism_bits=0, state=CLEAN.
REQ-035 SHALL cover: samples 0x00/0x00 then 0x0F/0x00 -> z=0xF0, mism_samples=1, mism_bits=4, first_idx=1, first_seen=1, state=ERR.
REQ-036 SHALL cover: MODE=1, x=0x3C, y=0x0F -> z=0x33.
REQ-037 SHALL cover: CNT_W=4 with 16 samples 0xFF/0x00 -> mism_bits stops at 15 after sample 2, state=SAT, samples frozen at 2, z keeps updating.
REQ-038 SHALL cover: clear and in_valid both 1 with x != y in ERR -> next cycle all counters 0, first_seen=0, state=CLEAN, z updated, z_valid=1.
REQ-039 SHALL cover: resetn=0 held for one cycle in ERR with in_valid=1 -> all outputs 0, state=CLEAN.
